// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard sequencer states and the hard-wired zero register.
package pipe_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2,
      ILLEGAL  = 2'd3
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for hazards forwarding cannot cover: load-use stall,
// taken-branch flush window and data-memory freeze with timeout detection.
module hazard_ctrl_unit
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs_IF_ID,
   input  logic [4:0]       rt_IF_ID,
   input  logic             uses_rt_IF_ID,
   input  logic [4:0]       rt_ID_EX,
   input  logic             MemRead_ID_EX,
   input  logic             branch_taken_EX,
   input  logic             mem_busy,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_flush,
   output logic             EX_MEM_write,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_err,
   output logic [1:0]       state_o
);
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam state_e     BR_NEXT    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_e     state, state_nxt, ret_state, eff;
   logic [2:0] flush_ctr, flush_ctr_nxt;
   logic [7:0] wait_ctr;
   logic       load_use, stall_inc;

   assign load_use = MemRead_ID_EX && (rt_ID_EX != REG_ZERO) &&
                     ((rt_ID_EX == rs_IF_ID) || (uses_rt_IF_ID && rt_ID_EX == rt_IF_ID));

   // On leaving a freeze the cycle behaves as the state that was interrupted.
   assign eff = (state == MEM_WAIT) ? ret_state : state;

   always_comb begin
      PC_write      = 1'b1;
      IF_ID_write   = 1'b1;
      ID_EX_write   = 1'b1;
      EX_MEM_write  = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      state_nxt     = RUN;
      flush_ctr_nxt = flush_ctr;
      stall_inc     = 1'b0;
      if (rst) begin
         flush_ctr_nxt = '0;
      end else if (mem_busy) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
         state_nxt    = MEM_WAIT;
         stall_inc    = 1'b1;
      end else begin
         case (eff)
            RUN: begin
               if (branch_taken_EX) begin
                  IF_ID_flush   = 1'b1;
                  ID_EX_flush   = 1'b1;
                  flush_ctr_nxt = FLUSH_INIT;
                  state_nxt     = BR_NEXT;
               end else if (load_use) begin
                  PC_write    = 1'b0;
                  IF_ID_write = 1'b0;
                  ID_EX_flush = 1'b1;
                  stall_inc   = 1'b1;
               end
            end
            FLUSH: begin
               IF_ID_flush = 1'b1;
               ID_EX_flush = 1'b1;
               if (branch_taken_EX) begin
                  flush_ctr_nxt = FLUSH_INIT;
                  state_nxt     = BR_NEXT;
               end else begin
                  flush_ctr_nxt = (flush_ctr == 3'd0) ? 3'd0 : flush_ctr - 3'd1;
                  state_nxt     = (flush_ctr <= 3'd1) ? RUN : FLUSH;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         ret_state <= RUN;
         flush_ctr <= '0;
         mem_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_ctr <= flush_ctr_nxt;
         if (mem_busy && state != MEM_WAIT)
            ret_state <= (state == FLUSH) ? FLUSH : RUN;
         if (mem_busy && wait_ctr >= 8'(MEM_TIMEOUT - 1))
            mem_err <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(8)) u_wait_ctr (
      .clk (clk),
      .clr (rst || !mem_busy),
      .inc (mem_busy),
      .cnt (wait_ctr)
   );

   assign state_o = state;
endmodule
